// File: rtl/inst_sram_slave_pkg.sv
// Shared definitions for the instruction SRAM read responder: response codes,
// FSM state encoding, delay counter width and the LFSR used when
// INST_SRAM_RAND_DELAY_EN is defined.
package inst_sram_slave_pkg;

  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;
  localparam logic [1:0] RRESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  // Wide enough for any practical LATENCY plus the 3-bit random extension.
  localparam int unsigned CNT_W = 16;

  // Fibonacci LFSR, taps 8,6,5,4 (state bits 7,5,4,3), shifting towards the MSB.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/inst_sram_lfsr.sv
// 8-bit Fibonacci LFSR with advance enable; used to stretch the response delay
// when INST_SRAM_RAND_DELAY_EN is defined.
module inst_sram_lfsr
  import inst_sram_slave_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  output logic [7:0] o_state
);

  logic [7:0] r_state;

  // Advance one step per enabled cycle; reseed on reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= LFSR_SEED;
    end else if (i_en) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/inst_sram_slave.sv
// Read-only instruction SRAM responder: one outstanding AR/R transaction,
// programmable response latency, side-band preload port.
// Optional: INST_SRAM_RAND_DELAY_EN adds an LFSR-driven 0..7 cycle extra delay.
module inst_sram_slave
  import inst_sram_slave_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  io_slave_arvalid,
  output logic                  io_slave_arready,
  input  logic [31:0]           io_slave_araddr,
  output logic                  io_slave_rvalid,
  input  logic                  io_slave_rready,
  output logic [1:0]            io_slave_rresp,
  output logic [31:0]           io_slave_rdata,
  input  logic                  init_wen,
  input  logic [DEPTH_LOG2-1:0] init_addr,
  input  logic [31:0]           init_wdata
);

  localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN_BYTES = 33'd4 << DEPTH_LOG2;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [CNT_W-1:0]      w_delay;
  logic [31:0]           r_addr;
  logic [31:0]           r_rdata;
  logic [1:0]            r_rresp;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_capture;
  logic [31:0]           w_off;
  logic                  w_misaligned;
  logic                  w_out_of_range;
  logic [DEPTH_LOG2-1:0] w_idx;

  assign io_slave_arready = (r_state == ST_IDLE);
  assign io_slave_rvalid  = (r_state == ST_RESP);
  assign io_slave_rresp   = r_rresp;
  assign io_slave_rdata   = r_rdata;

  assign w_ar_hs = io_slave_arvalid && io_slave_arready;
  assign w_r_hs  = io_slave_rvalid && io_slave_rready;

`ifdef INST_SRAM_RAND_DELAY_EN
  logic [7:0] w_lfsr;
  logic       w_lfsr_unused;

  inst_sram_lfsr u_lfsr (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (w_ar_hs),
    .o_state (w_lfsr)
  );

  // Value before the advance: the LFSR only steps on the same edge.
  assign w_delay       = CNT_W'(LATENCY) + CNT_W'(w_lfsr[2:0]);
  assign w_lfsr_unused = ^w_lfsr[7:3];
`else
  assign w_delay = CNT_W'(LATENCY);
`endif

  // Address decode of the latched request; wrap-around makes addresses below
  // ADDR_BASE land in the out-of-range bucket.
  assign w_off          = r_addr - ADDR_BASE;
  assign w_misaligned   = (w_off[1:0] != 2'b00);
  assign w_out_of_range = ({1'b0, w_off} >= SPAN_BYTES);
  assign w_idx          = w_off[DEPTH_LOG2+1:2];

  // WAIT with a zero count doubles as the response setup cycle, so LATENCY=0
  // still passes through it and rvalid rises one edge after the handshake.
  assign w_capture = (r_state == ST_WAIT) && (r_cnt == '0);

  // State and delay counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_ar_hs) begin
          w_cnt_nxt   = w_delay;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_RESP: begin
        if (w_r_hs) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Latch the request address and capture the response on entry to RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_rdata <= '0;
      r_rresp <= RRESP_OKAY;
    end else begin
      if (w_ar_hs) begin
        r_addr <= io_slave_araddr;
      end
      if (w_capture) begin
        if (w_misaligned) begin
          r_rresp <= RRESP_SLVERR;
          r_rdata <= '0;
        end else if (w_out_of_range) begin
          r_rresp <= RRESP_DECERR;
          r_rdata <= '0;
        end else begin
          r_rresp <= RRESP_OKAY;
          r_rdata <= r_mem[w_idx];
        end
      end
    end
  end

  // Preload port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (init_wen) begin
      r_mem[init_addr] <= init_wdata;
    end
  end

endmodule

// File: doc/inst_sram_slave.md
Name: inst_sram_slave

Overview:
- Read-only SRAM responder that answers the instruction fetch unit's AR/R read channels: it accepts one address, waits a programmable latency, then returns one 32-bit word.
- Sits between the fetch unit and the instruction memory array in simulation and FPGA builds.
- Includes a side-band preload port so benches and boot logic can fill the array.
- One outstanding transaction; no bursts; no ID.

Parameters:
- ADDR_BASE, 32'h8000_0000, byte address of word 0.
- DEPTH_LOG2, 12, log2 of the number of 32-bit words.
- LATENCY, 1, cycles between the AR handshake and the cycle before rvalid rises (0 allowed).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- io_slave_arvalid  in  1  read address valid
- io_slave_arready  out  1  read address ready
- io_slave_araddr  in  32  byte address
- io_slave_rvalid  out  1  read data valid
- io_slave_rready  in  1  read data ready
- io_slave_rresp  out  2  response: 00 OKAY, 10 SLVERR, 11 DECERR
- io_slave_rdata  out  32  read data
- init_wen  in  1  preload write enable
- init_addr  in  DEPTH_LOG2  preload word index
- init_wdata  in  32  preload data

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: arready=1, rvalid=0, rresp=00, rdata=0, state=IDLE, delay counter=0. Memory contents are not reset.
- States:
  - IDLE: arready=1. When arvalid&&arready: latch araddr, drop arready, load counter with LATENCY. Go to WAIT if LATENCY>0, otherwise go directly to RESP setup.
  - WAIT: counter decrements each cycle. When it reaches 0, the next state is RESP.
  - RESP: rvalid=1; rdata/rresp captured on entry and held stable while rvalid&&!rready. On rvalid&&rready: rvalid=0, arready=1, state=IDLE, all on the following edge.
- Timing: AR handshake at edge T gives rvalid=1 from edge T+1+LATENCY. The next arready=1 comes the cycle after the R handshake. Peak throughput is one beat per LATENCY+2 cycles.
- Decode:
  - off = addr-ADDR_BASE.
  - off[1:0]!=0 → rresp=10, rdata=0.
  - off >= 4<<DEPTH_LOG2 (unsigned, includes addr<ADDR_BASE via wrap) → rresp=11, rdata=0.
  - Otherwise rresp=00, rdata=mem[off[DEPTH_LOG2+1:2]].
- Preload: init_wen writes mem[init_addr] on the rising edge, in any state. If it writes the word being captured on RESP entry in the same cycle, the old data is returned.
- arvalid while arready=0 is ignored; the master must hold the request.
- araddr is sampled only at the handshake.
- rready without rvalid has no effect.
- Reset mid-transaction: the transaction is abandoned, outputs return to reset values immediately (asynchronously), and no response is later issued.

Optional Feature:
- Macro: INST_SRAM_RAND_DELAY_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'hA5) advances once per AR handshake.
  - Effective delay = LATENCY + lfsr[2:0], using the LFSR value before the advance.
  - This exercises master stall handling.
- Undefined: fixed LATENCY; no LFSR logic present.

Decomposition:
- Shared package:
  - RRESP_OKAY / RRESP_SLVERR / RRESP_DECERR constants.
  - State encoding for IDLE/WAIT/RESP.
  - LFSR seed and tap constants.
- One natural sub-module: inst_sram_lfsr (8-bit LFSR with enable, asynchronous active-low reset, 8-bit state output), instantiated only under INST_SRAM_RAND_DELAY_EN.
- Memory array stays in the top module.

Test Plan:
- Reset/basic read:
  - Stimulus: preload mem[0]=32'h0000_0413; LATENCY=1; arvalid at addr 32'h8000_0000, rready tied 1.
  - Required: arready=1 out of reset; rvalid rises 2 edges after the handshake with rdata=32'h0000_0413, rresp=00; arready=1 again one cycle after the R handshake.
- Backpressure:
  - Stimulus: read addr 32'h8000_0004 (mem[1]=32'hDEAD_BEEF), rready=0 for 5 cycles, then 1.
  - Required: rvalid stays 1 and rdata stays 32'hDEAD_BEEF throughout; exactly one handshake; arready stays 0 until after it.
- Error decode:
  - Stimulus: addr 32'h8000_0002, then 32'h8000_4000 (DEPTH_LOG2=12), then 32'h7FFF_FFFC.
  - Required: rresp=10, then 11, then 11; rdata=0 for all three.
- Zero latency / back-to-back:
  - Stimulus: LATENCY=0; arvalid held high for 4 sequential addresses; rready=1.
  - Required: rvalid one edge after each handshake; handshakes every 2 cycles; data in order.
- Preload collision and mid-read reset:
  - Stimulus: init_wen to the word being captured in the same cycle; separately, rst_n low during WAIT.
  - Required: the collision read returns the old value; after reset, rvalid=0 immediately and no stray response is issued.
- Random delay (macro defined):
  - Stimulus: 64 reads.
  - Required: every response data is correct; observed latencies span LATENCY..LATENCY+7 and match a reference LFSR model seeded with 8'hA5.
